// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
//
// Timed phase scheduler for a two-street intersection. Street A is the
// priority street and Street B is the side street. A pedestrian crossing
// can also be served. The block guarantees:
//   - a minimum green time on A,
//   - a bounded green time on B while A has traffic,
//   - fixed yellow and all-red clearance intervals,
//   - a protected walk phase.
// The signal heads are driven straight from registers, so no input can
// reach a lamp through combinational logic.
//
// Build option:
//   TLC_PED_EN  When defined, the pedestrian logic is built: a pending
//               request flag, the walk phase, and the walk/ped_ack lamps.
//               When it is undefined, ped_req is ignored, walk and ped_ack
//               are tied low, and A yields only to Street B traffic.
//
// Ports:
//   clk       clock; all state changes on its rising edge
//   reset     asynchronous, active-high reset
//   sensor_A  a vehicle is present on Street A (level)
//   sensor_B  a vehicle is present on Street B (level)
//   ped_req   pedestrian push button (pulse or level)
//   light_A   Street A head, one-hot: 001 green, 010 yellow, 100 red
//   light_B   Street B head, same encoding
//   walk      pedestrian WALK lamp
//   ped_ack   one-cycle pulse on the first cycle of the walk phase
//   phase     current phase code, for debug and status

module intersection_phase_scheduler #(
  parameter int CNT_W       = 8,
  parameter int A_MIN_GREEN = 8,
  parameter int B_MAX_GREEN = 16,
  parameter int YELLOW_CYC  = 4,
  parameter int ALLRED_CYC  = 2,
  parameter int WALK_CYC    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_A,
  input  logic       sensor_B,
  input  logic       ped_req,
  output logic [2:0] light_A,
  output logic [2:0] light_B,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [2:0] A_GREEN  = 3'd0;
  localparam logic [2:0] A_YELLOW = 3'd1;
  localparam logic [2:0] AR_TO_B  = 3'd2;
  localparam logic [2:0] B_GREEN  = 3'd3;
  localparam logic [2:0] B_YELLOW = 3'd4;
  localparam logic [2:0] AR_TO_A  = 3'd5;
  localparam logic [2:0] PED_WALK = 3'd6;

  // A timed phase of N cycles ends on the edge where the timer reads N-1.
  localparam logic [CNT_W-1:0] A_MIN_LAST  = CNT_W'(A_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] B_MAX_LAST  = CNT_W'(B_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       light_a_q, light_a_d;
  logic [2:0]       light_b_q, light_b_d;

  // These three terms are the only places where pedestrian handling
  // changes the phase sequence.
  logic yield_a;
  logic serve_b;
  logic walk_next;

`ifdef TLC_PED_EN
  logic ped_pending_q, ped_pending_d;
  logic tgt_q, tgt_d;
  logic walk_q, walk_d;
  logic ped_ack_q, ped_ack_d;

  assign yield_a   = sensor_B | ped_pending_q;
  assign serve_b   = tgt_q;
  assign walk_next = ped_pending_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign yield_a        = sensor_B;
  assign serve_b        = 1'b1;
  assign walk_next      = 1'b0;
`endif

  // Phase sequencing. An illegal code (7) falls back to A_GREEN.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      A_GREEN:  if (cnt_q >= A_MIN_LAST && yield_a) phase_d = A_YELLOW;
      A_YELLOW: if (cnt_q == YELLOW_LAST) phase_d = AR_TO_B;
      AR_TO_B:  if (cnt_q == ALLRED_LAST) phase_d = serve_b ? B_GREEN : PED_WALK;
      B_GREEN:  if (!sensor_B || (sensor_A && cnt_q >= B_MAX_LAST)) phase_d = B_YELLOW;
      B_YELLOW: if (cnt_q == YELLOW_LAST) phase_d = AR_TO_A;
      AR_TO_A:  if (cnt_q == ALLRED_LAST) phase_d = walk_next ? PED_WALK : A_GREEN;
      PED_WALK: if (cnt_q == WALK_LAST) phase_d = A_GREEN;
      default:  phase_d = A_GREEN;
    endcase
  end

  // The timer restarts on every phase change. It saturates so that a long
  // hold on B green cannot wrap around and hide the B_MAX_GREEN limit.
  always_comb begin
    cnt_d = cnt_q;
    if (phase_d != phase_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The lamps are decoded from the next phase and then registered, so they
  // change on the same edge as the phase register.
  always_comb begin
    light_a_d = 3'b100;
    light_b_d = 3'b100;
    case (phase_d)
      A_GREEN:  light_a_d = 3'b001;
      A_YELLOW: light_a_d = 3'b010;
      B_GREEN:  light_b_d = 3'b001;
      B_YELLOW: light_b_d = 3'b010;
      default:  ;
    endcase
  end

`ifdef TLC_PED_EN
  // A button press while walking is ignored. Entering the walk phase
  // consumes the pending request, and that takes priority over a press on
  // the same edge.
  always_comb begin
    ped_pending_d = ped_pending_q;
    tgt_d         = tgt_q;
    walk_d        = (phase_d == PED_WALK);
    ped_ack_d     = (phase_d == PED_WALK) && (phase_q != PED_WALK);
    if (ped_ack_d) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && phase_q != PED_WALK) begin
      ped_pending_d = 1'b1;
    end
    // When B and the pedestrian both want the yield, B is served first.
    // The walk then follows through AR_TO_A.
    if (phase_q == A_GREEN && phase_d == A_YELLOW) begin
      tgt_d = sensor_B;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending_q <= 1'b0;
      tgt_q         <= 1'b0;
      walk_q        <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
      tgt_q         <= tgt_d;
      walk_q        <= walk_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  assign walk    = walk_q;
  assign ped_ack = ped_ack_q;
`else
  assign walk    = 1'b0;
  assign ped_ack = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= A_GREEN;
      cnt_q     <= '0;
      light_a_q <= 3'b001;
      light_b_q <= 3'b100;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      light_a_q <= light_a_d;
      light_b_q <= light_b_d;
    end
  end

  assign light_A = light_a_q;
  assign light_B = light_b_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler
//
// Bench for intersection_phase_scheduler. The bench keeps a timeline model
// of the intersection. The model tracks which phase is showing, how long it
// has been showing, and whether a walk request is still owed. One process
// compares the DUT with this model on every falling clock edge. A set of
// directed scenarios then pins the model to hand-worked cycle numbers. A
// long randomized run follows. The bench sees the same TLC_PED_EN define
// as the design.

`timescale 1ns/1ps

module tb_intersection_phase_scheduler;

  localparam int A_MIN = 8;
  localparam int B_MAX = 16;
  localparam int YEL   = 4;
  localparam int AR    = 2;
  localparam int WALK  = 12;

  localparam logic [2:0] P_AG  = 3'd0;
  localparam logic [2:0] P_AY  = 3'd1;
  localparam logic [2:0] P_ARB = 3'd2;
  localparam logic [2:0] P_BG  = 3'd3;
  localparam logic [2:0] P_BY  = 3'd4;
  localparam logic [2:0] P_ARA = 3'd5;
  localparam logic [2:0] P_PW  = 3'd6;

`ifdef TLC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       sensor_A = 1'b0;
  logic       sensor_B = 1'b0;
  logic       ped_req  = 1'b0;
  logic [2:0] light_A;
  logic [2:0] light_B;
  logic [2:0] phase;
  logic       walk;
  logic       ped_ack;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  intersection_phase_scheduler #(
    .CNT_W(8), .A_MIN_GREEN(A_MIN), .B_MAX_GREEN(B_MAX),
    .YELLOW_CYC(YEL), .ALLRED_CYC(AR), .WALK_CYC(WALK)
  ) dut (
    .clk(clk), .reset(reset), .sensor_A(sensor_A), .sensor_B(sensor_B),
    .ped_req(ped_req), .light_A(light_A), .light_B(light_B),
    .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  // The model state is a plain timeline: the showing phase, the number of
  // cycles it has already shown (unbounded), whether a walk is owed, and
  // which side the current yield serves.
  typedef struct packed {
    logic [2:0] ph;
    int         el;
    logic       pend;
    logic       tgt;
    logic       ack;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t cur, input logic sa,
                                        input logic sb, input logic pr);
    model_t nx;
    int     held;
    nx   = cur;
    held = cur.el + 1;
    case (cur.ph)
      P_AG:  if (held >= A_MIN && (sb || cur.pend)) begin
               nx.ph  = P_AY;
               nx.tgt = sb;
             end
      P_AY:  if (held == YEL) nx.ph = P_ARB;
      P_ARB: if (held == AR) nx.ph = (cur.tgt || !PED_EN) ? P_BG : P_PW;
      P_BG:  if (!sb || (sa && held >= B_MAX)) nx.ph = P_BY;
      P_BY:  if (held == YEL) nx.ph = P_ARA;
      P_ARA: if (held == AR) nx.ph = (PED_EN && cur.pend) ? P_PW : P_AG;
      P_PW:  if (held == WALK) nx.ph = P_AG;
      default: nx.ph = P_AG;
    endcase
    nx.ack = (nx.ph == P_PW) && (cur.ph != P_PW);
    if (nx.ack) nx.pend = 1'b0;
    else if (PED_EN && pr && cur.ph != P_PW) nx.pend = 1'b1;
    nx.el = (nx.ph != cur.ph) ? 0 : held;
    return nx;
  endfunction

  function automatic logic [2:0] exp_light_a(input logic [2:0] ph);
    if (ph == P_AG) return 3'b001;
    if (ph == P_AY) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_light_b(input logic [2:0] ph);
    if (ph == P_BG) return 3'b001;
    if (ph == P_BY) return 3'b010;
    return 3'b100;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_next(m, sensor_A, sensor_B, ped_req);
  end

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic sa, input logic sb, input logic pr);
    sensor_A = sa;
    sensor_B = sb;
    ped_req  = pr;
  endtask

  // Pulses reset. On return, reset has just been released at a falling
  // edge. That moment is cycle 0, with the given inputs already applied.
  task automatic startRun(input logic sa, input logic sb, input logic pr);
    @(negedge clk);
    #2 reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(sa, sb, pr);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("phase",       8'(phase),   8'(m.ph));
      checkOutput("light_A",     8'(light_A), 8'(exp_light_a(m.ph)));
      checkOutput("light_B",     8'(light_B), 8'(exp_light_b(m.ph)));
      checkOutput("walk",        8'(walk),    8'(PED_EN && m.ph == P_PW));
      checkOutput("ped_ack",     8'(ped_ack), 8'(m.ack));
      checkOutput("no_conflict", 8'(light_A == 3'b001 && light_B == 3'b001), 8'd0);
    end
  end

  initial begin
    int  b_len;
    logic sa, sb;

    @(negedge clk);
    checkOutput("reset_phase",   8'(phase),   8'd0);
    checkOutput("reset_light_A", 8'(light_A), 8'b001);
    checkOutput("reset_light_B", 8'(light_B), 8'b100);
    checkOutput("reset_walk",    8'(walk),    8'd0);
    checkOutput("reset_ped_ack", 8'(ped_ack), 8'd0);
    check_en = 1'b1;

    // Scenario 1: B waits while A serves its minimum green. A ped request
    // is then made during B green (ped build only), and reset hits mid-B.
    $display("[TB] scenario: B request with minimum A green");
    startRun(1'b0, 1'b1, 1'b0);
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 7)  checkOutput("s1_c7_phase",  8'(phase), 8'd0);
      if (c == 8)  checkOutput("s1_c8_phase",  8'(phase), 8'd1);
      if (c == 9)  checkOutput("s1_c9_light_A", 8'(light_A), 8'b010);
      if (c == 9)  checkOutput("s1_c9_light_B", 8'(light_B), 8'b100);
      if (c == 12) checkOutput("s1_c12_phase", 8'(phase), 8'd2);
      if (c == 14) checkOutput("s1_c14_phase", 8'(phase), 8'd3);
      if (c == 20) checkOutput("s1_c20_phase", 8'(phase), 8'd3);
`ifdef TLC_PED_EN
      if (c == 16) applyStimulus(1'b0, 1'b1, 1'b1);
      if (c == 17) applyStimulus(1'b0, 1'b1, 1'b0);
`endif
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_light_A", 8'(light_A), 8'b001);
    checkOutput("async_rst_light_B", 8'(light_B), 8'b100);
    checkOutput("async_rst_walk",    8'(walk),    8'd0);
    checkOutput("async_rst_phase",   8'(phase),   8'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 12) checkOutput("post_rst_no_pending", 8'(phase), 8'd0);
    end

    // Scenario 2: both streams busy. B green is capped and the cycle repeats.
    $display("[TB] scenario: both streets busy");
    startRun(1'b1, 1'b1, 1'b0);
    b_len = 0;
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) @(negedge clk);
      if (phase == P_BG) b_len++;
      if (c == 29) checkOutput("s2_c29_phase", 8'(phase), 8'd3);
      if (c == 30) checkOutput("s2_c30_phase", 8'(phase), 8'd4);
      if (c == 34) checkOutput("s2_c34_phase", 8'(phase), 8'd5);
      if (c == 36) checkOutput("s2_c36_phase", 8'(phase), 8'd0);
      if (c == 43) checkOutput("s2_c43_phase", 8'(phase), 8'd0);
      if (c == 44) checkOutput("s2_c44_phase", 8'(phase), 8'd1);
    end
    checkOutput("s2_b_green_len", 8'(b_len), 8'd16);

`ifdef TLC_PED_EN
    // Scenario 3: a lone pedestrian pulse with no vehicles present.
    $display("[TB] scenario: pedestrian pulse only");
    startRun(1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 27; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 3) applyStimulus(1'b0, 1'b0, 1'b1);
      if (c == 4) applyStimulus(1'b0, 1'b0, 1'b0);
      if (c == 7)  checkOutput("s3_c7_phase",  8'(phase), 8'd0);
      if (c == 8)  checkOutput("s3_c8_phase",  8'(phase), 8'd1);
      if (c == 12) checkOutput("s3_c12_phase", 8'(phase), 8'd2);
      if (c == 14) checkOutput("s3_c14_phase", 8'(phase), 8'd6);
      if (c == 14) checkOutput("s3_c14_ack",   8'(ped_ack), 8'd1);
      if (c == 14) checkOutput("s3_c14_walk",  8'(walk), 8'd1);
      if (c == 15) checkOutput("s3_c15_ack",   8'(ped_ack), 8'd0);
      if (c == 25) checkOutput("s3_c25_walk",  8'(walk), 8'd1);
      if (c == 26) checkOutput("s3_c26_phase", 8'(phase), 8'd0);
      if (c == 26) checkOutput("s3_c26_walk",  8'(walk), 8'd0);
    end

    // Scenario 4: B and pedestrian at the same yield. B goes first, then the
    // walk. A press during the walk does not trigger another walk.
    $display("[TB] scenario: simultaneous B and pedestrian");
    startRun(1'b0, 1'b1, 1'b0);
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2)  applyStimulus(1'b0, 1'b1, 1'b1);
      if (c == 3)  applyStimulus(1'b0, 1'b1, 1'b0);
      if (c == 16) applyStimulus(1'b0, 1'b0, 1'b0);
      if (c == 25) applyStimulus(1'b0, 1'b0, 1'b1);
      if (c == 26) applyStimulus(1'b0, 1'b0, 1'b0);
      if (c == 14) checkOutput("s4_c14_phase", 8'(phase), 8'd3);
      if (c == 17) checkOutput("s4_c17_phase", 8'(phase), 8'd4);
      if (c == 21) checkOutput("s4_c21_phase", 8'(phase), 8'd5);
      if (c == 23) checkOutput("s4_c23_phase", 8'(phase), 8'd6);
      if (c == 23) checkOutput("s4_c23_ack",   8'(ped_ack), 8'd1);
      if (c == 35) checkOutput("s4_c35_phase", 8'(phase), 8'd0);
      if (c == 50) checkOutput("s4_c50_phase", 8'(phase), 8'd0);
      if (c == 50) checkOutput("s4_c50_walk",  8'(walk), 8'd0);
    end
`else
    // Scenario 5: without pedestrian support, a held button changes nothing.
    $display("[TB] scenario: button held, pedestrian logic absent");
    startRun(1'b0, 1'b0, 1'b1);
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 10 || c == 30 || c == 60) begin
        checkOutput("s5_phase",   8'(phase),   8'd0);
        checkOutput("s5_light_A", 8'(light_A), 8'b001);
        checkOutput("s5_walk",    8'(walk),    8'd0);
        checkOutput("s5_ped_ack", 8'(ped_ack), 8'd0);
      end
    end
`endif

    // Randomized traffic. The sensors are sticky levels, the button gives
    // short pulses, and an occasional reset lands mid-cycle.
    $display("[TB] scenario: randomized traffic");
    startRun(1'b0, 1'b0, 1'b0);
    sa = 1'b0;
    sb = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) sa = ~sa;
      if ($urandom_range(0, 7) == 0) sb = ~sb;
      applyStimulus(sa, sb, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Timed phase scheduler for the two-street intersection (Street A = priority, Street B = side street) plus a pedestrian crossing. It replaces the untimed light FSM. It enforces a minimum green on A, a bounded green on B, fixed yellow and all-red clearance intervals, and a protected pedestrian walk phase. Outputs drive the signal heads directly.

Parameters:
CNT_W, 8, width of the phase timer
A_MIN_GREEN, 8, minimum cycles A stays green before yielding (>=1)
B_MAX_GREEN, 16, maximum cycles B stays green while A has traffic (>=1)
YELLOW_CYC, 4, yellow interval in cycles (>=1)
ALLRED_CYC, 2, all-red clearance interval in cycles (>=1)
WALK_CYC, 12, pedestrian walk interval in cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
sensor_A  in  1  vehicle present on Street A (level)
sensor_B  in  1  vehicle present on Street B (level)
ped_req  in  1  pedestrian button (pulse or level)
light_A  out  3  Street A head, one-hot: 001 green, 010 yellow, 100 red
light_B  out  3  Street B head, same encoding
walk  out  1  pedestrian WALK lamp
ped_ack  out  1  one-cycle pulse on entry to the walk phase
phase  out  3  current state code (for debug/status)

Behaviour:
- Clock and reset: reset is asynchronous and active-high; clock is clk. All state is updated on posedge clk.
- States and phase codes: A_GREEN=0, A_YELLOW=1, AR_TO_B=2, B_GREEN=3, B_YELLOW=4, AR_TO_A=5, PED_WALK=6. Code 7 is illegal and recovers to A_GREEN on the next edge.
- Reset values: phase=A_GREEN, cnt=0, tgt=0, ped_pending=0, light_A=001, light_B=100, walk=0, ped_ack=0.
- Lights by state:
  - A_GREEN: A=001, B=100.
  - A_YELLOW: A=010, B=100.
  - B_GREEN: A=100, B=001.
  - B_YELLOW: A=100, B=010.
  - AR_TO_B, AR_TO_A, PED_WALK: both heads 100.
  - walk=1 only in PED_WALK.
- Timer: cnt clears to 0 on every state change. Otherwise it increments and saturates at all-ones. A timed state of N cycles exits on the edge where cnt==N-1.
- ped_pending: set on any cycle with ped_req=1, except while in PED_WALK (requests there are ignored). It is cleared on the edge entering PED_WALK. ped_ack=1 for exactly the first PED_WALK cycle.
- A_GREEN -> A_YELLOW when cnt>=A_MIN_GREEN-1 and (sensor_B or ped_pending). On that edge, latch tgt=1 if sensor_B, else tgt=0 (pedestrian). Otherwise remain in A_GREEN indefinitely.
- A_YELLOW -> AR_TO_B after YELLOW_CYC cycles.
- AR_TO_B -> B_GREEN if tgt=1, else PED_WALK, after ALLRED_CYC cycles.
- B_GREEN -> B_YELLOW when sensor_B=0, or when sensor_A=1 and cnt>=B_MAX_GREEN-1. With sensor_A=0, B holds green as long as sensor_B=1. Minimum B green is 1 cycle.
- B_YELLOW -> AR_TO_A after YELLOW_CYC cycles.
- AR_TO_A -> PED_WALK if ped_pending, else A_GREEN, after ALLRED_CYC cycles.
- PED_WALK -> A_GREEN after WALK_CYC cycles. A pending B request is served on the next A yield, after A_MIN_GREEN.
- Simultaneous B and pedestrian requests at the A yield: B is served first, then the walk phase via AR_TO_A.
- Conflicting greens are never permitted. At least one head shows 100 in every state, and green never directly follows green.
- Reset mid-phase: immediate return to reset values, with pending requests discarded.
- Outputs are registered-decoded from the state: no combinational path from the inputs to the lights.

Optional Feature:
TLC_PED_EN.
- Defined: pedestrian logic as described above.
- Undefined:
  - PED_WALK is unreachable; ped_req is ignored; walk and ped_ack are tied 0; ped_pending is not built.
  - A_GREEN yields only on sensor_B.
  - AR_TO_B always goes to B_GREEN; AR_TO_A always goes to A_GREEN.
  - Port list is unchanged.

Test Plan:
- Reset, then sensor_B=1 held and sensor_A=0 from cycle 0, defaults.
  - A_GREEN for cycles 0-7, A_YELLOW 8-11, AR_TO_B 12-13, B_GREEN from 14 and held while sensor_B=1.
  - Check light_A=010 and light_B=100 at cycle 9.
- sensor_A=1 and sensor_B=1 held.
  - B_GREEN lasts exactly 16 cycles, then B_YELLOW 4, AR_TO_A 2, A_GREEN 8.
  - The cycle then repeats; light_B never shows 001 while light_A shows 001.
- Single-cycle ped_req pulse at cycle 3, no vehicles.
  - Yield at cycle 7 with tgt=0; PED_WALK entered at cycle 14 with ped_ack=1 for one cycle.
  - walk=1 for 12 cycles, then A_GREEN.
- ped_req and sensor_B both active at yield.
  - Sequence is B_GREEN -> B_YELLOW -> AR_TO_A -> PED_WALK -> A_GREEN.
  - ped_req during PED_WALK does not re-trigger a walk.
- Assert reset during B_GREEN.
  - Outputs immediately show light_A=001, light_B=100, walk=0, phase=0 without waiting for a clock edge.
  - Prior pending requests are gone.
- Build with TLC_PED_EN undefined and ped_req=1 held.
  - walk=0 and ped_ack=0 throughout; lights stay A_GREEN forever with sensor_B=0.
